apb_to_obi_bridge: RTL and testbench

//  APB subordinate to OBI manager bridge: an external APB host gets load/store access into the

---
 rtl/apb_to_obi_bridge.sv | 131 +++++++++++++
 tb/tb_apb_to_obi_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_to_obi_bridge.sv
// -----------------------------------------------------------------------------
// apb_to_obi_bridge
//   APB subordinate to OBI manager bridge. An external APB host issues one
//   load/store at a time; the bridge replays it as a single OBI transfer and
//   returns the response as an APB completion. There is one outstanding
//   transfer and no buffering beyond the captured request and its response.
//
//   Sequence: IDLE (capture on psel_i) -> REQ (obi_req_o until grant)
//             -> RESP (wait for rvalid) -> DONE (pready_o pulse) -> IDLE
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   psel_i .. pstrb_i        APB request (penable_i is not needed: a transfer
//                            is captured on the first cycle psel_i is seen)
//   prdata_o                 registered read data, held until the next response
//   pready_o                 one-cycle completion pulse per transfer
//   pslverr_o                error flag, only meaningful while pready_o=1
//   obi_req_o .. obi_wdata_o registered OBI request, stable until grant
//   obi_gnt_i                OBI grant
//   obi_rvalid_i .. obi_err_i OBI response
// -----------------------------------------------------------------------------
module apb_to_obi_bridge #(
    parameter int unsigned           AddrWidth = 32,
    parameter int unsigned           DataWidth = 32,
    parameter logic [AddrWidth-1:0]  BaseAddr  = {AddrWidth{1'b0}}
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic                     pwrite_i,
    input  logic [AddrWidth-1:0]     paddr_i,
    input  logic [DataWidth-1:0]     pwdata_i,
    input  logic [DataWidth/8-1:0]   pstrb_i,
    output logic [DataWidth-1:0]     prdata_o,
    output logic                     pready_o,
    output logic                     pslverr_o,
    output logic                     obi_req_o,
    input  logic                     obi_gnt_i,
    output logic [AddrWidth-1:0]     obi_addr_o,
    output logic                     obi_we_o,
    output logic [DataWidth/8-1:0]   obi_be_o,
    output logic [DataWidth-1:0]     obi_wdata_o,
    input  logic                     obi_rvalid_i,
    input  logic [DataWidth-1:0]     obi_rdata_i,
    input  logic                     obi_err_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e state_r;

    // penable_i carries no information for this bridge: capture happens on
    // psel_i alone so the setup cycle already starts the OBI transfer.
    logic unused_s;
    assign unused_s = penable_i;

    // Transfer sequencer; every output is a register written only here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            prdata_o    <= {DataWidth{1'b0}};
            pready_o    <= 1'b0;
            pslverr_o   <= 1'b0;
            obi_req_o   <= 1'b0;
            obi_addr_o  <= {AddrWidth{1'b0}};
            obi_we_o    <= 1'b0;
            obi_be_o    <= {BeWidth{1'b0}};
            obi_wdata_o <= {DataWidth{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    if (psel_i) begin
                        // Address add wraps naturally at AddrWidth bits.
                        obi_addr_o  <= BaseAddr + paddr_i;
                        obi_we_o    <= pwrite_i;
                        obi_wdata_o <= pwdata_i;
                        // Reads fetch the full word; writes keep the strobes,
                        // including an all-zero strobe.
                        obi_be_o    <= pwrite_i ? pstrb_i : {BeWidth{1'b1}};
                        obi_req_o   <= 1'b1;
                        state_r     <= REQ;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                REQ: begin
                    // rvalid cannot belong to this transfer yet, so it is ignored here.
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        state_r   <= RESP;
                    end else begin
                        state_r   <= REQ;
                    end
                end
                RESP: begin
                    if (obi_rvalid_i) begin
                        prdata_o  <= obi_we_o ? {DataWidth{1'b0}} : obi_rdata_i;
                        pslverr_o <= obi_err_i;
                        pready_o  <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                DONE: begin
                    // Leaving through IDLE guarantees a gap cycle between transfers.
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    obi_req_o <= 1'b0;
                    pready_o  <= 1'b0;
                    pslverr_o <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_to_obi_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_to_obi_bridge
//   Self-checking bench: an APB host task drives one transfer at a time and an
//   OBI subordinate with programmable grant/response stalls answers it. The
//   expected address, byte enables, read data, error and completion latency
//   are computed from the transfer parameters.
// -----------------------------------------------------------------------------
module tb_apb_to_obi_bridge;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;

    int n_vec = 0;
    int n_err = 0;

    apb_to_obi_bridge #(
        .AddrWidth (32),
        .DataWidth (32),
        .BaseAddr  (BASE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pstrb_i      (pstrb),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .obi_err_i    (obi_err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_reset(input string tag);
        chk_val({tag, "_req"},    {31'b0, obi_req}, 32'd0);
        chk_val({tag, "_pready"}, {31'b0, pready},  32'd0);
        chk_val({tag, "_slverr"}, {31'b0, pslverr}, 32'd0);
        chk_val({tag, "_prdata"}, prdata,           32'd0);
        chk_val({tag, "_addr"},   obi_addr,         32'd0);
        chk_val({tag, "_we"},     {31'b0, obi_we},  32'd0);
        chk_val({tag, "_be"},     {28'b0, obi_be},  32'd0);
        chk_val({tag, "_wdata"},  obi_wdata,        32'd0);
    endtask

    // One APB transfer, called at a negedge with the bridge idle.
    // gd/rd: grant and response stall cycles of the OBI subordinate.
    // hold: keep psel high afterwards (back-to-back); drop: release psel
    // mid-transfer; rst_mid: reset the bridge while it waits for rvalid.
    task automatic apb_xfer(input bit wr, input logic [31:0] pa, input logic [31:0] wd,
                            input logic [3:0] st, input int gd, input int rd,
                            input logic [31:0] rdat, input bit er,
                            input bit hold, input bit drop, input bit rst_mid);
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_rdata;
        int          n;
        int          phase;
        int          reqcnt;
        int          k;
        bit          seen;
        e_addr  = BASE + pa;
        e_be    = wr ? st : 4'hF;
        e_rdata = wr ? 32'd0 : rdat;
        n = 0; phase = 0; reqcnt = 0; k = 0; seen = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = pa; pwdata = wd; pstrb = st;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            penable    = psel;
            if (drop && n == 2) begin
                psel    = 1'b0;
                penable = 1'b0;
            end
            obi_gnt    = 1'b0;
            obi_rvalid = 1'b0;
            obi_rdata  = $urandom;
            obi_err    = 1'($urandom_range(0, 1));
            if (n == 1) chk_val("req_start", {31'b0, obi_req}, 32'd1);
            if (phase == 0) begin
                // Spurious rvalid while the request is pending must be ignored.
                obi_rvalid = 1'($urandom_range(0, 1));
                if (obi_req) begin
                    reqcnt++;
                    chk_val("obi_addr",  obi_addr,         e_addr);
                    chk_val("obi_we",    {31'b0, obi_we},  {31'b0, wr});
                    chk_val("obi_be",    {28'b0, obi_be},  {28'b0, e_be});
                    chk_val("obi_wdata", obi_wdata,        wd);
                    if (reqcnt == gd + 1) begin
                        obi_gnt = 1'b1;
                        phase   = 1;
                    end
                end
            end else if (phase == 1) begin
                k++;
                if (k == 1) begin
                    chk_val("req_drop", {31'b0, obi_req}, 32'd0);
                    if (rst_mid) begin
                        #2 rst_n = 1'b0;
                        #1 chk_all_reset("rst_mid");
                        obi_rvalid = 1'b0; obi_gnt = 1'b0;
                        psel = 1'b0; penable = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        return;
                    end
                end
                if (k == rd + 1) begin
                    obi_rvalid = 1'b1;
                    obi_rdata  = rdat;
                    obi_err    = er;
                    phase      = 2;
                end
            end
            if (pready) begin
                seen = 1'b1;
                chk_val("latency", 32'(n), 32'(3 + gd + rd));
                chk_val("prdata",  prdata, e_rdata);
                chk_val("slverr",  {31'b0, pslverr}, {31'b0, er});
            end
        end
        if (!seen) chk_val("timeout", {31'b0, seen}, 32'd1);
        @(negedge clk);
        obi_gnt    = 1'b0;
        obi_rvalid = 1'b0;
        penable    = 1'b0;
        if (!hold) psel = 1'b0;
        chk_val("pready_pulse", {31'b0, pready},  32'd0);
        chk_val("slverr_pulse", {31'b0, pslverr}, 32'd0);
        chk_val("prdata_hold",  prdata, e_rdata);
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0;
        pwdata = 32'd0; pstrb = 4'd0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
        obi_rdata = 32'd0; obi_err = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // wrapped read address, no stalls
        apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        // partial write with a 3-cycle grant stall
        apb_xfer(1'b1, 32'h4, 32'hA5A5_0001, 4'h3, 3, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        // error response
        apb_xfer(1'b0, 32'h100, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0);
        // zero-strobe misaligned write still goes out
        apb_xfer(1'b1, 32'h13, 32'h0BAD_0BAD, 4'h0, 1, 2, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset while waiting for the response, then a clean read
        apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 2, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 1'b1);
        apb_xfer(1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 32'h3333_4444, 1'b0, 1'b0, 1'b0, 1'b0);
        // back-to-back reads with psel held
        apb_xfer(1'b0, 32'h80, 32'h0, 4'h0, 0, 0, 32'h0102_0304, 1'b0, 1'b1, 1'b0, 1'b0);
        apb_xfer(1'b0, 32'h84, 32'h0, 4'h0, 0, 0, 32'h0506_0708, 1'b0, 1'b0, 1'b0, 1'b0);
        // psel released mid-transfer
        apb_xfer(1'b0, 32'h88, 32'h0, 4'h0, 2, 1, 32'h9999_8888, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit hold;
            bit drop;
            hold = ($urandom_range(0, 3) == 0);
            drop = !hold && ($urandom_range(0, 7) == 0);
            apb_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 4), $urandom_range(0, 4), $urandom,
                     1'($urandom_range(0, 1)), hold, drop, 1'b0);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        psel = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
